// File: rtl/pe_operand_packer.sv
// Operand packer: gathers low-precision input/weight element pairs into one packed
// 8-bit word per operand, laid out for the multiplier diagonal of the selected mode.
package pe_operand_packer_pkg;
   typedef enum logic [2:0] {
      AU_XNOR = 3'd0,
      AU_M1   = 3'd1,
      AU_M2   = 3'd2,
      AU_M4   = 3'd3,
      AU_M8   = 3'd4
   } au_mode_e;

   typedef struct packed {
      au_mode_e mode;
      logic     isgn;
      logic     wsgn;
   } au_ctl_t;

   function automatic logic [3:0] lane_w(au_mode_e m);
      case (m)
         AU_M2:   lane_w = 4'd2;
         AU_M4:   lane_w = 4'd4;
         AU_M8:   lane_w = 4'd8;
         default: lane_w = 4'd1;
      endcase
   endfunction

   function automatic logic [3:0] lane_n(au_mode_e m);
      case (m)
         AU_M2:   lane_n = 4'd4;
         AU_M4:   lane_n = 4'd2;
         AU_M8:   lane_n = 4'd1;
         default: lane_n = 4'd8;
      endcase
   endfunction
endpackage

module pe_operand_packer
   import pe_operand_packer_pkg::*;
#(
   parameter logic PAD_I = 1'b0,
   parameter logic PAD_W = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  au_ctl_t    i_ctl,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [7:0] i_ielem,
   input  logic [7:0] i_welem,
   input  logic       i_last,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [7:0] o_ipix,
   output logic [7:0] o_wpix,
   output au_ctl_t    o_ctl,
   output logic [3:0] o_nlane,
   output logic       o_last
);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_e;

   state_e     state, state_n;
   logic [7:0] fb_i, fb_w;
   au_ctl_t    fb_ctl;
   logic [3:0] cnt;
   logic       fb_last;

   au_ctl_t    ctl_eff, src_ctl;
   logic [3:0] lw, nl, lane, kl, sh_i, cnt_n, src_cnt, fbits;
   logic [7:0] lmask, base_i, base_w, new_i, new_w, src_i, src_w;
   logic [7:0] fill_i, fill_w, pk_i, pk_w;
   logic       accept, complete, or_free, xfer, src_last, pad_w_en;

   assign o_ready = (state != FULL);
   assign accept  = i_valid && o_ready;
   assign or_free = !o_valid || i_ready;

   // Lane write: a fresh word starts from an all-zero buffer, so OR-ing is enough
   always_comb begin
      ctl_eff  = (state == IDLE) ? i_ctl : fb_ctl;
      lane     = (state == IDLE) ? 4'd0 : cnt;
      base_i   = (state == IDLE) ? 8'd0 : fb_i;
      base_w   = (state == IDLE) ? 8'd0 : fb_w;
      lw       = lane_w(ctl_eff.mode);
      nl       = lane_n(ctl_eff.mode);
      lmask    = 8'((9'd1 << lw) - 9'd1);
      kl       = 4'(lane * lw);
      sh_i     = 4'd8 - kl - lw;
      new_w    = base_w | ((i_welem & lmask) << kl);
      new_i    = base_i | ((i_ielem & lmask) << sh_i);
      cnt_n    = lane + 4'd1;
      complete = accept && ((cnt_n == nl) || i_last);
   end

   // Transfer source: the word held in FB when FULL, otherwise the one completing now
   always_comb begin
      src_i    = (state == FULL) ? fb_i    : new_i;
      src_w    = (state == FULL) ? fb_w    : new_w;
      src_ctl  = (state == FULL) ? fb_ctl  : ctl_eff;
      src_cnt  = (state == FULL) ? cnt     : cnt_n;
      src_last = (state == FULL) ? fb_last : i_last;
      xfer     = (state == FULL) ? or_free : (complete && or_free);
      fbits    = 4'(src_cnt * lane_w(src_ctl.mode));
      fill_w   = 8'((9'd1 << fbits) - 9'd1);
      pad_w_en = PAD_W && (src_ctl.mode == AU_XNOR);
   end

   // Input lanes fill from the MSB, so their occupancy mask is the weight mask mirrored
   for (genvar b = 0; b < 8; b++) begin : g_bit
      assign fill_i[b] = fill_w[7-b];
      assign pk_i[b]   = src_i[b] | (PAD_I & ~fill_i[b]);
      assign pk_w[b]   = src_w[b] | (pad_w_en & ~fill_w[b]);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, FILL: if (accept) state_n = complete ? (or_free ? IDLE : FULL) : FILL;
         FULL:       if (or_free) state_n = IDLE;
         default:    state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         fb_i    <= '0;
         fb_w    <= '0;
         fb_ctl  <= '0;
         fb_last <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            fb_i    <= new_i;
            fb_w    <= new_w;
            fb_ctl  <= ctl_eff;
            fb_last <= i_last;
            cnt     <= (state_n == IDLE) ? 4'd0 : cnt_n;
         end else if (xfer) begin
            cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_ipix  <= '0;
         o_wpix  <= '0;
         o_ctl   <= '0;
         o_nlane <= '0;
         o_last  <= 1'b0;
      end else if (xfer) begin
         o_valid <= 1'b1;
         o_ipix  <= pk_i;
         o_wpix  <= pk_w;
         o_ctl   <= src_ctl;
         o_nlane <= src_cnt;
         o_last  <= src_last;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pe_operand_packer.sv
// Directed and randomized bench for pe_operand_packer against a queue-based word model.
module tb_pe_operand_packer;
   import pe_operand_packer_pkg::*;

   localparam logic PI = 1'b0;
   localparam logic PW = 1'b1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   au_ctl_t    i_ctl, o_ctl;
   logic       i_valid, o_ready, i_last, o_valid, i_ready, o_last;
   logic [7:0] i_ielem, i_welem, o_ipix, o_wpix;
   logic [3:0] o_nlane;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   pe_operand_packer #(.PAD_I(PI), .PAD_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .i_ctl(i_ctl), .i_valid(i_valid), .o_ready(o_ready),
      .i_ielem(i_ielem), .i_welem(i_welem), .i_last(i_last), .o_valid(o_valid),
      .i_ready(i_ready), .o_ipix(o_ipix), .o_wpix(o_wpix), .o_ctl(o_ctl),
      .o_nlane(o_nlane), .o_last(o_last)
   );

   typedef struct packed {
      logic [7:0] ip;
      logic [7:0] wp;
      au_ctl_t    ctl;
      logic [3:0] n;
      logic       last;
   } word_t;

   word_t   pend[$];
   word_t   or_w = '0;
   bit      or_v = 1'b0;
   int      ei[$];
   int      ew[$];
   au_ctl_t cur_ctl = '0;

   function automatic int bits_of(au_mode_e m);
      if (m == AU_M8) return 8;
      if (m == AU_M4) return 4;
      if (m == AU_M2) return 2;
      return 1;
   endfunction

   function automatic au_ctl_t mk(au_mode_e m);
      au_ctl_t c;
      c.mode = m;
      c.isgn = 1'b0;
      c.wsgn = 1'b0;
      return c;
   endfunction

   function automatic word_t make_word(bit last);
      word_t r;
      int L = bits_of(cur_ctl.mode);
      int N = 8 / L;
      int m = (1 << L) - 1;
      int ip = 0;
      int wp = 0;
      for (int k = 0; k < N; k++) begin
         if (k < ei.size()) begin
            wp += (ew[k] & m) << (k * L);
            ip += (ei[k] & m) << (8 - (k + 1) * L);
         end else begin
            if (PI) ip += m << (8 - (k + 1) * L);
            if (PW && cur_ctl.mode == AU_XNOR) wp += m << (k * L);
         end
      end
      r.ip   = 8'(ip);
      r.wp   = 8'(wp);
      r.ctl  = cur_ctl;
      r.n    = 4'(ei.size());
      r.last = last;
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      pend.delete();
      ei.delete();
      ew.delete();
      or_v = 1'b0;
      or_w = '0;
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model
   task automatic cyc(bit iv, logic [7:0] ie, logic [7:0] we, bit il, au_ctl_t c, bit ir);
      bit rdy, drain;
      @(negedge clk);
      i_valid = iv; i_ielem = ie; i_welem = we; i_last = il; i_ctl = c; i_ready = ir;
      rdy = (pend.size() == 0);
      chk("o_ready", 32'(o_ready), 32'(rdy));
      chk("o_valid", 32'(o_valid), 32'(or_v));
      if (or_v) begin
         chk("o_ipix", 32'(o_ipix), 32'(or_w.ip));
         chk("o_wpix", 32'(o_wpix), 32'(or_w.wp));
         chk("o_ctl", 32'(o_ctl), 32'(or_w.ctl));
         chk("o_nlane", 32'(o_nlane), 32'(or_w.n));
         chk("o_last", 32'(o_last), 32'(or_w.last));
      end
      @(posedge clk);
      drain = or_v && ir;
      if (iv && rdy) begin
         if (ei.size() == 0) cur_ctl = c;
         ei.push_back(int'(ie));
         ew.push_back(int'(we));
         if (ei.size() == 8 / bits_of(cur_ctl.mode) || il) begin
            pend.push_back(make_word(il));
            ei.delete();
            ew.delete();
         end
      end
      if ((!or_v || drain) && pend.size() != 0) begin
         or_w = pend.pop_front();
         or_v = 1'b1;
      end else if (drain) begin
         or_v = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] a, b;
      au_ctl_t    rc;
      i_valid = 0; i_ielem = 0; i_welem = 0; i_last = 0; i_ctl = '0; i_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ipix", 32'(o_ipix), 32'd0);
      chk("rst_wpix", 32'(o_wpix), 32'd0);
      chk("rst_ctl", 32'(o_ctl), 32'd0);
      chk("rst_nlane", 32'(o_nlane), 32'd0);
      chk("rst_last", 32'(o_last), 32'd0);
      rst_n = 1'b1;
      #1 chk("rst_ready", 32'(o_ready), 32'd1);

      // M2 full word
      cyc(1, 8'd1, 8'd3, 0, mk(AU_M2), 1);
      cyc(1, 8'd2, 8'd2, 0, mk(AU_M2), 1);
      cyc(1, 8'd3, 8'd1, 0, mk(AU_M2), 1);
      cyc(1, 8'd0, 8'd0, 0, mk(AU_M2), 1);
      #1;
      chk("t1_valid", 32'(o_valid), 32'd1);
      chk("t1_ipix", 32'(o_ipix), 32'b01101100);
      chk("t1_wpix", 32'(o_wpix), 32'b00011011);
      chk("t1_nlane", 32'(o_nlane), 32'd4);
      cyc(0, 8'd0, 8'd0, 0, mk(AU_M2), 1);

      // M4 backpressure: OR and FB both fill, then drain in order
      for (int k = 0; k < 4; k++) cyc(1, 8'($urandom), 8'($urandom), 0, mk(AU_M4), 0);
      #1 chk("t2_ready_low", 32'(o_ready), 32'd0);
      for (int k = 0; k < 2; k++) cyc(1, 8'($urandom), 8'($urandom), 0, mk(AU_M4), 0);
      for (int k = 0; k < 3; k++) cyc(0, 8'd0, 8'd0, 0, mk(AU_M4), 1);

      // XNOR short word closed by i_last
      cyc(1, 8'd1, 8'd1, 0, mk(AU_XNOR), 1);
      cyc(1, 8'd1, 8'd0, 0, mk(AU_XNOR), 1);
      cyc(1, 8'd1, 8'd1, 1, mk(AU_XNOR), 1);
      #1;
      chk("t3_ipix", 32'(o_ipix), 32'b11100000);
      chk("t3_wpix", 32'(o_wpix), 32'b11111101);
      chk("t3_nlane", 32'(o_nlane), 32'd3);
      chk("t3_last", 32'(o_last), 32'd1);

      // M8 streaming
      for (int k = 0; k < 10; k++) begin
         a = 8'($urandom); b = 8'($urandom);
         cyc(1, a, b, 0, mk(AU_M8), 1);
         #1;
         chk("t4_ipix", 32'(o_ipix), 32'(a));
         chk("t4_wpix", 32'(o_wpix), 32'(b));
         chk("t4_ready", 32'(o_ready), 32'd1);
      end
      cyc(0, 8'd0, 8'd0, 0, mk(AU_M8), 0);

      // M1 half word, then async reset discards it and the held output
      for (int k = 0; k < 4; k++) cyc(1, 8'($urandom), 8'($urandom), 0, mk(AU_M1), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_valid_rst", 32'(o_valid), 32'd0);
      mreset();
      #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) cyc(1, 8'($urandom), 8'($urandom), 0, mk(AU_M1), 1);
      #1;
      chk("t5_valid", 32'(o_valid), 32'd1);
      chk("t5_nlane", 32'(o_nlane), 32'd8);
      cyc(0, 8'd0, 8'd0, 0, mk(AU_M1), 1);

      // Mode change mid-word is ignored until the next word
      cyc(1, 8'($urandom), 8'($urandom), 0, mk(AU_M2), 1);
      for (int k = 0; k < 3; k++) cyc(1, 8'($urandom), 8'($urandom), 0, mk(AU_M4), 1);
      #1 chk("t6_mode_m2", 32'(o_ctl.mode), 32'(AU_M2));
      for (int k = 0; k < 2; k++) cyc(1, 8'($urandom), 8'($urandom), 0, mk(AU_M4), 1);
      #1;
      chk("t6_mode_m4", 32'(o_ctl.mode), 32'(AU_M4));
      chk("t6_nlane", 32'(o_nlane), 32'd2);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         rc.mode = au_mode_e'($urandom_range(0, 4));
         rc.isgn = 1'($urandom);
         rc.wsgn = 1'($urandom);
         cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
             $urandom_range(0, 7) == 0, rc, 1'($urandom_range(0, 2) != 0));
      end
      for (int k = 0; k < 4; k++) cyc(0, 8'd0, 8'd0, 0, mk(AU_M1), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
